// File: rtl/parity_frame_tx.sv
// parity_frame_tx
//   Serial frame transmitter that sits after the even parity generator. It takes
//   one data word plus its even parity bit over a valid/ready handshake and sends
//   one frame, LSB first: start(0), DATA_W data bits, parity bit, stop(1).
//   The parity bit is transmitted unchanged, even on a mismatch. The block also
//   recomputes even parity on the accepted word and pulses par_err if the two disagree.
//
// Parameters
//   DATA_W        data word width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; aborts any frame in progress
//   data      in   word to transmit
//   even_p    in   even parity bit accompanying data
//   in_valid  in   data/even_p valid
//   in_ready  out  high only while idle (word can be accepted)
//   tx        out  serial line, idles high (registered)
//   busy      out  frame in progress
//   done      out  one-cycle pulse during the last cycle of the stop bit (registered)
//   par_err   out  one-cycle pulse the cycle after accept on parity mismatch (registered)
module parity_frame_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              even_p,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              par_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity of a word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity_of(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  state_t            state_r, state_n;
  logic [DIV_W-1:0]  div_r, div_n;
  logic [BIT_W-1:0]  bit_r, bit_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic              par_r, par_n;
  logic              tx_r, tx_n;
  logic              done_r, done_n;
  logic              par_err_r, par_err_n;
  logic              wrap_s;

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);
  assign tx       = tx_r;
  assign done     = done_r;
  assign par_err  = par_err_r;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      div_r     <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      div_r     <= div_n;
      bit_r     <= bit_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      tx_r      <= tx_n;
      done_r    <= done_n;
      par_err_r <= par_err_n;
    end
  end

  // Next-state, divider, bit counter and shift register.
  always_comb begin
    state_n   = state_r;
    div_n     = div_r;
    bit_n     = bit_r;
    shift_n   = shift_r;
    par_n     = par_r;
    par_err_n = 1'b0;
    wrap_s    = (div_r == DIV_LAST);

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_n   = START;
          div_n     = '0;
          bit_n     = '0;
          shift_n   = data;
          par_n     = even_p;
          par_err_n = even_p ^ even_parity_of(data);
        end else begin
          state_n   = IDLE;
        end
      end
      START: begin
        if (wrap_s) begin
          state_n = DATA;
          div_n   = '0;
        end else begin
          div_n   = div_r + DIV_ONE;
        end
      end
      DATA: begin
        if (wrap_s) begin
          div_n   = '0;
          shift_n = shift_r >> 1;
          if (bit_r == BIT_LAST) begin
            state_n = PARITY;
            bit_n   = '0;
          end else begin
            bit_n   = bit_r + BIT_ONE;
          end
        end else begin
          div_n   = div_r + DIV_ONE;
        end
      end
      PARITY: begin
        if (wrap_s) begin
          state_n = STOP;
          div_n   = '0;
        end else begin
          div_n   = div_r + DIV_ONE;
        end
      end
      STOP: begin
        if (wrap_s) begin
          state_n = IDLE;
          div_n   = '0;
        end else begin
          div_n   = div_r + DIV_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Line level and done are derived from the upcoming state so that the
  // registered copies line up with the state they describe.
  always_comb begin
    tx_n   = 1'b1;
    done_n = (state_n == STOP) && (div_n == DIV_LAST);
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

  logic       clk;
  logic       rst;
  logic [2:0] data;
  logic       even_p;
  logic       in_valid;

  logic in_ready0, tx0, busy0, done0, par_err0;
  logic in_ready1, tx1, busy1, done1, par_err1;

  int tests_run;
  int tests_failed;

  parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut_slow (
    .clk(clk), .rst(rst), .data(data), .even_p(even_p), .in_valid(in_valid),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .done(done0), .par_err(par_err0)
  );

  parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(1)) dut_fast (
    .clk(clk), .rst(rst), .data(data), .even_p(even_p), .in_valid(in_valid),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1), .par_err(par_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected DUT view: fast=1 picks the CLKS_PER_BIT=1 instance.
  logic fast;
  logic m_ready, m_tx, m_busy, m_done, m_err;
  assign m_ready = fast ? in_ready1 : in_ready0;
  assign m_tx    = fast ? tx1       : tx0;
  assign m_busy  = fast ? busy1     : busy0;
  assign m_done  = fast ? done1     : done0;
  assign m_err   = fast ? par_err1  : par_err0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word and checks every cycle of its frame. exp_bits[0] is the
  // first bit on the line (start). With hold=1 in_valid stays high afterwards.
  // gap_zero=1 requires the DUT to be ready immediately (back-to-back case).
  task automatic send_frame(input string name, input logic [2:0] d, input logic p,
                            input logic [5:0] exp_bits, input logic exp_err,
                            input logic hold, input logic gap_zero);
    int cpb;
    int total;
    int waited;
    int bad_tx, bad_done, bad_err, bad_busy, err_pulses;
    cpb = fast ? 1 : 4;
    total = 6 * cpb;
    data = d;
    even_p = p;
    in_valid = 1'b1;
    waited = 0;
    while (!m_ready && waited < 100) begin
      step();
      waited++;
    end
    tests_run++;
    if (!m_ready || (gap_zero && waited != 0)) begin
      tests_failed++;
      $display("FAIL %s ready_wait: waited %0d cycles, ready=%b, required ready with gap_zero=%b",
               name, waited, m_ready, gap_zero);
    end
    step();
    if (!hold) in_valid = 1'b0;
    bad_tx = 0; bad_done = 0; bad_err = 0; bad_busy = 0; err_pulses = 0;
    for (int c = 1; c <= total; c++) begin
      if (m_tx !== exp_bits[(c - 1) / cpb]) begin
        bad_tx++;
        $display("FAIL %s tx cycle %0d: got %b, required %b", name, c, m_tx, exp_bits[(c - 1) / cpb]);
      end
      if (m_done !== (c == total)) begin
        bad_done++;
        $display("FAIL %s done cycle %0d: got %b, required %b", name, c, m_done, (c == total));
      end
      if (m_err === 1'b1) err_pulses++;
      if (m_err !== (exp_err && c == 1)) begin
        bad_err++;
        $display("FAIL %s par_err cycle %0d: got %b, required %b", name, c, m_err, (exp_err && c == 1));
      end
      if (m_busy !== 1'b1 || m_ready !== 1'b0) begin
        bad_busy++;
        $display("FAIL %s busy/ready cycle %0d: got busy=%b ready=%b, required 1/0", name, c, m_busy, m_ready);
      end
      step();
    end
    tests_run += 4;
    if (bad_tx != 0) tests_failed++;
    if (bad_done != 0) tests_failed++;
    if (bad_err != 0 || err_pulses != (exp_err ? 1 : 0)) tests_failed++;
    if (bad_busy != 0) tests_failed++;
    tests_run++;
    if (m_ready !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0 || m_tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s idle_after: got ready=%b busy=%b done=%b tx=%b, required 1 0 0 1",
               name, m_ready, m_busy, m_done, m_tx);
    end
  endtask

  task automatic test_reset();
    fast = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    data = 3'b000;
    even_p = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (tx0 !== 1'b1 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || par_err0 !== 1'b0 ||
          tx1 !== 1'b1 || in_ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || par_err1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset idle cycle %0d: got tx=%b ready=%b busy=%b done=%b err=%b, required 1 1 0 0 0",
                 i, tx0, in_ready0, busy0, done0, par_err0);
      end
      step();
    end
  endtask

  task automatic test_single_frame();
    fast = 1'b0;
    // 101, p=0: line 0,1,0,1,0,1
    send_frame("frame_101", 3'b101, 1'b0, 6'b101010, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    fast = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] d;
      d = 3'(k);
      exp = {1'b1, ^d, d, 1'b0};
      send_frame($sformatf("sweep_%0d", k), d, ^d, exp, 1'b0, 1'b1, (k != 0));
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_parity_error();
    fast = 1'b0;
    // 011 with wrong p=1: line 0,1,1,0,1,1
    send_frame("bad_parity_011", 3'b011, 1'b1, 6'b110110, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    fast = 1'b0;
    data = 3'b000;
    even_p = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) step();
    tests_run++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset pre: got tx=%b busy=%b at cycle 10, required 0 1", tx0, busy0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || in_ready0 !== 1'b1 || done0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset abort: got tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx0, busy0, in_ready0, done0);
    end
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done0 !== 1'b0 || tx0 !== 1'b1) done_seen++;
      step();
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL midreset quiet: got %0d cycles with done or tx low, required 0", done_seen);
    end
    send_frame("after_reset_110", 3'b110, 1'b0, 6'b101100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_one_clk_per_bit();
    fast = 1'b1;
    // 110, p=0, one cycle per bit: line 0,0,1,1,0,1
    send_frame("fast_110", 3'b110, 1'b0, 6'b101100, 1'b0, 1'b0, 1'b0);
    send_frame("fast_111_bad", 3'b111, 1'b0, 6'b100000 | 6'b001110, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    fast = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    data = 3'b000;
    even_p = 1'b0;
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_reset_mid_frame();
    test_one_clk_per_bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
